vga_sync_generator: RTL and testbench
=====================================

# vga_sync_generator

Generates VGA raster timing for the display path. Free-running horizontal and vertical pixel counters produce active-low sync pulses, a blanking/active flag and frame markers. It sits directly upstream of the color application stage and drives its `horizontal` and `vertical` inputs. Default timing is 640x480 @ 60 Hz (800x525 total).

## Interface
Parameters:
- `H_ACTIVE`, 640: visible pixels per line
- `H_FP`, 16: horizontal front porch
- `H_SYNC`, 96: horizontal sync width
- `H_BP`, 48: horizontal back porch
- `V_ACTIVE`, 480: visible lines per frame
- `V_FP`, 10: vertical front porch
- `V_SYNC`, 2: vertical sync width
- `V_BP`, 33: vertical back porch

Ports:
- `clk_in`  input  1  system clock, rising edge
- `reset_in`  input  1  reset, asynchronous, active-low
- `horizontal`  output  10  current pixel column, 0..H_TOTAL-1
- `vertical`  output  10  current line, 0..V_TOTAL-1
- `hsync_n`  output  1  horizontal sync, active-low
- `vsync_n`  output  1  vertical sync, active-low
- `video_on`  output  1  high while (horizontal, vertical) is in the visible area
- `pixel_tick`  output  1  high for the clk_in cycles in which the counters advance
- `frame_start`  output  1  one-clock pulse when the counters wrap to (0,0)

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP. V_TOTAL is defined the same way. Both must be ≤ 1024; a larger value is an elaboration error.
- On each pixel tick, `horizontal` increments.
- At H_TOTAL-1, `horizontal` wraps to 0 and `vertical` increments. At V_TOTAL-1 the vertical counter also wraps to 0.
- `hsync_n` = 0 iff H_ACTIVE+H_FP ≤ horizontal ≤ H_ACTIVE+H_FP+H_SYNC-1 (defaults 656..751).
- `vsync_n` = 0 iff V_ACTIVE+V_FP ≤ vertical ≤ V_ACTIVE+V_FP+V_SYNC-1 (defaults 490..491).
- `video_on` = (horizontal < H_ACTIVE) && (vertical < V_ACTIVE).
- All outputs are registered. The sync, video_on and frame_start registers load from the next-count values on the same edge as the counters, so they always correspond to the currently presented `horizontal`/`vertical`.
- `frame_start` = 1 for exactly the clk_in cycle following the edge on which the counters wrap from (H_TOTAL-1, V_TOTAL-1) to (0,0).

## Timing
- Reset values:
  - `horizontal`=0, `vertical`=0
  - `hsync_n`=1, `vsync_n`=1
  - `video_on`=0, `pixel_tick`=0, `frame_start`=0
- Consequence of the reset values: pixel (0,0) of the first frame after reset is blanked. This is accepted.
- Latency: counter to outputs is 0 cycles (same register stage). Reset release to first counter advance: see Configuration.
- Reset asserted mid-frame: all outputs return to their reset values immediately (asynchronous reset). The raster restarts from (0,0) after release.
- No handshake: the block is free-running and never stalls.

## Configuration
- `VGA_SYNC_DIV2_EN` defined:
  - An internal toggle register (reset 0) divides clk_in by 2.
  - `pixel_tick` is high on every second clk_in cycle, starting with the second cycle after reset release.
  - The counters advance only on those cycles, giving a 25 MHz pixel rate from a 50 MHz board clock.
- Not defined:
  - `pixel_tick` is 0 during reset and constant 1 afterwards.
  - The counters advance on every clk_in edge, starting with the first edge after release.

## Structure
- Package `vga_timing_pkg` holds:
  - the default timing constants
  - the counter width (10)
  - the derived H_TOTAL/V_TOTAL and sync-start/sync-end localparams
  - a typedef `coord_t` for the 10-bit coordinate
- One sub-module, `vga_axis_counter`:
  - parameterised wrapping counter with inputs clock, reset and enable, and parameter MAX
  - outputs the count and a `wrap` flag (count==MAX && enable)
  - instantiated twice: horizontal uses enable=pixel tick; vertical uses enable=horizontal wrap.

## Test plan
- Reset held 10 cycles, then released: all outputs equal their reset values during reset. The first counter advance gives horizontal=1, vertical=0, video_on=1, hsync_n=1.
- Run to horizontal=639→640: video_on falls on the tick to 640. hsync_n falls at 656 and rises at 752. On 799→0, vertical increments by 1.
- Run to vertical 489→490: vsync_n falls at 490 and rises at 492. video_on stays 0 for all lines 480..524.
- Frame wrap from (799,524) to (0,0): frame_start is high for exactly one clk_in cycle, and two consecutive pulses are 420000 pixel ticks apart.
- Assert reset_in at (300,200), asynchronously between edges: outputs reach reset values before the next edge. After release the counting restarts at (0,0).
- With VGA_SYNC_DIV2_EN defined, one line takes exactly 1600 clk_in cycles and pixel_tick has a 50% duty cycle. Without the macro, one line takes 800 cycles.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// VGA timing constants, derived totals and sync windows for the 640x480@60 raster.
// Shared by the sync generator, its axis counters and its interface.
package vga_timing_pkg;
    localparam int COORD_W = 10;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;

    localparam int H_TOTAL      = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int V_TOTAL      = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;
    localparam int H_SYNC_START = H_ACTIVE_DEF + H_FP_DEF;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC_DEF - 1;
    localparam int V_SYNC_START = V_ACTIVE_DEF + V_FP_DEF;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC_DEF - 1;

    typedef logic [COORD_W-1:0] coord_t;
endpackage

// File: rtl/vga_sync_generator_if.sv
// Raster timing bundle from the sync generator to the colour stage.
// Free-running: no handshake, the consumer samples every clock.
interface vga_sync_generator_if;
    import vga_timing_pkg::*;

    coord_t horizontal;
    coord_t vertical;
    logic   hsync_n;
    logic   vsync_n;
    logic   video_on;
    logic   pixel_tick;
    logic   frame_start;

    modport master (output horizontal, vertical, hsync_n, vsync_n, video_on, pixel_tick, frame_start);
    modport slave  (input  horizontal, vertical, hsync_n, vsync_n, video_on, pixel_tick, frame_start);
endinterface

// File: rtl/vga_axis_counter.sv
// Wrapping 0..MAX counter for one raster axis; exposes next count so callers can register in step.
// Zero latency from enable to count_nxt; never stalls.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int MAX = H_TOTAL - 1
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   en,
    output coord_t count,
    output coord_t count_nxt,
    output logic   wrap
);
    localparam coord_t MAX_C = coord_t'(MAX);

    coord_t count_q, count_d;

    always_comb begin
        count_d = count_q;
        wrap    = 1'b0;
        if (en) begin
            if (count_q == MAX_C) begin
                count_d = '0;
                wrap    = 1'b1;
            end else begin
                count_d = count_q + coord_t'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) count_q <= '0;
        else        count_q <= count_d;
    end

    assign count     = count_q;
    assign count_nxt = count_d;
endmodule

// File: rtl/vga_sync_generator.sv
// Free-running VGA raster timing; all outputs registered alongside the counters, never stalls.
// VGA_SYNC_DIV2_EN: advance the raster every second clk_in cycle instead of every cycle.
module vga_sync_generator
    import vga_timing_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int H_FP     = H_FP_DEF,
    parameter int H_SYNC   = H_SYNC_DEF,
    parameter int H_BP     = H_BP_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF,
    parameter int V_FP     = V_FP_DEF,
    parameter int V_SYNC   = V_SYNC_DEF,
    parameter int V_BP     = V_BP_DEF
) (
    input  logic                   clk_in,
    input  logic                   reset_in,
    vga_sync_generator_if.master   vga
);
    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam coord_t H_ACT_C = coord_t'(H_ACTIVE);
    localparam coord_t V_ACT_C = coord_t'(V_ACTIVE);
    localparam coord_t HS_BEG  = coord_t'(H_ACTIVE + H_FP);
    localparam coord_t HS_END  = coord_t'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam coord_t VS_BEG  = coord_t'(V_ACTIVE + V_FP);
    localparam coord_t VS_END  = coord_t'(V_ACTIVE + V_FP + V_SYNC - 1);

    if (H_TOT > 1024 || V_TOT > 1024) begin : g_range_check
        $error("vga_sync_generator: H_TOTAL/V_TOTAL exceed 10-bit coordinate range");
    end

    logic tick_en;

`ifdef VGA_SYNC_DIV2_EN
    logic div_q, div_d;

    always_comb div_d = ~div_q;

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) div_q <= 1'b0;
        else           div_q <= div_d;
    end

    assign tick_en = div_q;
`else
    assign tick_en = 1'b1;
`endif

    coord_t h_cnt, h_nxt, v_cnt, v_nxt;
    logic   h_wrap, v_wrap;

    vga_axis_counter #(.MAX(H_TOT - 1)) u_h_cnt (
        .clk(clk_in), .rst_n(reset_in), .en(tick_en),
        .count(h_cnt), .count_nxt(h_nxt), .wrap(h_wrap)
    );

    vga_axis_counter #(.MAX(V_TOT - 1)) u_v_cnt (
        .clk(clk_in), .rst_n(reset_in), .en(h_wrap),
        .count(v_cnt), .count_nxt(v_nxt), .wrap(v_wrap)
    );

    logic hsync_n_q, hsync_n_d, vsync_n_q, vsync_n_d;
    logic video_on_q, video_on_d, pixel_tick_q, pixel_tick_d, frame_start_q, frame_start_d;

    // Decode from next-count values so the flags line up with the presented counters.
    always_comb begin
        hsync_n_d     = !((h_nxt >= HS_BEG) && (h_nxt <= HS_END));
        vsync_n_d     = !((v_nxt >= VS_BEG) && (v_nxt <= VS_END));
        video_on_d    = (h_nxt < H_ACT_C) && (v_nxt < V_ACT_C);
        pixel_tick_d  = tick_en;
        frame_start_d = v_wrap;
    end

    always_ff @(posedge clk_in or negedge reset_in) begin
        if (!reset_in) begin
            hsync_n_q     <= 1'b1;
            vsync_n_q     <= 1'b1;
            video_on_q    <= 1'b0;
            pixel_tick_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            hsync_n_q     <= hsync_n_d;
            vsync_n_q     <= vsync_n_d;
            video_on_q    <= video_on_d;
            pixel_tick_q  <= pixel_tick_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign vga.horizontal  = h_cnt;
    assign vga.vertical    = v_cnt;
    assign vga.hsync_n     = hsync_n_q;
    assign vga.vsync_n     = vsync_n_q;
    assign vga.video_on    = video_on_q;
    assign vga.pixel_tick  = pixel_tick_q;
    assign vga.frame_start = frame_start_q;
endmodule

// File: tb/tb_vga_sync_generator.sv
// Scoreboard bench: default-timing and reduced-timing instances checked every cycle against an
// arithmetic raster model, with random async resets and line/frame period checks.
module tb_vga_sync_generator;
    import vga_timing_pkg::*;

`ifdef VGA_SYNC_DIV2_EN
    localparam int DIV = 2;
`else
    localparam int DIV = 1;
`endif
    localparam int SHA = 64, SHF = 8, SHS = 12, SHB = 6;
    localparam int SVA = 20, SVF = 3, SVS = 2, SVB = 4;
    localparam int FRAME_S = (SHA + SHF + SHS + SHB) * (SVA + SVF + SVS + SVB);

    typedef struct packed {
        logic [9:0] h;
        logic [9:0] v;
        logic       hs;
        logic       vs;
        logic       vo;
        logic       pt;
        logic       fs;
    } obs_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    vga_sync_generator_if vga_d();
    vga_sync_generator_if vga_s();

    vga_sync_generator dut_d (.clk_in(clk), .reset_in(rst_n), .vga(vga_d));
    vga_sync_generator #(
        .H_ACTIVE(SHA), .H_FP(SHF), .H_SYNC(SHS), .H_BP(SHB),
        .V_ACTIVE(SVA), .V_FP(SVF), .V_SYNC(SVS), .V_BP(SVB)
    ) dut_s (.clk_in(clk), .reset_in(rst_n), .vga(vga_s));

    obs_t q_d[$];
    obs_t q_s[$];
    int   edges   = 0;
    bit   started = 1'b0;
    int   checks  = 0;
    int   errors  = 0;
    int   cyc     = 0;
    int   last_line = -1;
    int   last_frame = -1;
    int   frame_gaps = 0;

    // Raster position is simply (pixel count) split into line and frame by division.
    function automatic obs_t model(int e, int ha, int hf, int hs, int hb,
                                   int va, int vf, int vs, int vb);
        obs_t o;
        int ht, vt, n, hh, vv;
        bit tick;
        ht = ha + hf + hs + hb;
        vt = va + vf + vs + vb;
        o  = '0;
        o.hs = 1'b1;
        o.vs = 1'b1;
        if (e == 0) return o;
        n    = e / DIV;
        tick = (e % DIV) == 0;
        hh   = n % ht;
        vv   = (n / ht) % vt;
        o.h  = 10'(hh);
        o.v  = 10'(vv);
        o.hs = !(hh >= ha + hf && hh < ha + hf + hs);
        o.vs = !(vv >= va + vf && vv < va + vf + vs);
        o.vo = (hh < ha) && (vv < va);
        o.pt = tick;
        o.fs = tick && hh == 0 && vv == 0;
        return o;
    endfunction

    function automatic obs_t model_d(int e);
        return model(e, H_ACTIVE_DEF, H_FP_DEF, H_SYNC_DEF, H_BP_DEF,
                     V_ACTIVE_DEF, V_FP_DEF, V_SYNC_DEF, V_BP_DEF);
    endfunction

    function automatic obs_t model_s(int e);
        return model(e, SHA, SHF, SHS, SHB, SVA, SVF, SVS, SVB);
    endfunction

    // Expected responses are queued at each edge; an async reset replaces the pending one.
    always @(posedge clk) begin
        if (!rst_n) edges = 0;
        else        edges = edges + 1;
        q_d.push_back(model_d(edges));
        q_s.push_back(model_s(edges));
        started = 1'b1;
    end

    always @(negedge rst_n) begin
        edges = 0;
        if (q_d.size() > 0) q_d[q_d.size()-1] = model_d(0);
        if (q_s.size() > 0) q_s[q_s.size()-1] = model_s(0);
    end

    task automatic cmp(string name, obs_t act, obs_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc %0d: got h=%0d v=%0d hs=%b vs=%b vo=%b pt=%b fs=%b, want h=%0d v=%0d hs=%b vs=%b vo=%b pt=%b fs=%b",
                     name, cyc, act.h, act.v, act.hs, act.vs, act.vo, act.pt, act.fs,
                     exp.h, exp.v, exp.hs, exp.vs, exp.vo, exp.pt, exp.fs);
        end
    endtask

    task automatic cmp_int(string name, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s cyc %0d: got %0d, want %0d", name, cyc, act, exp);
        end
    endtask

    task automatic pop_cmp_d(obs_t act);
        if (q_d.size() == 0) begin
            checks++; errors++;
            $display("FAIL scoreboard_d cyc %0d: no expected entry", cyc);
        end else begin
            cmp("raster_default", act, q_d.pop_front());
        end
    endtask

    task automatic pop_cmp_s(obs_t act);
        if (q_s.size() == 0) begin
            checks++; errors++;
            $display("FAIL scoreboard_s cyc %0d: no expected entry", cyc);
        end else begin
            cmp("raster_small", act, q_s.pop_front());
        end
    endtask

    always @(negedge clk) begin
        if (started) begin
            cyc = cyc + 1;
            pop_cmp_d({vga_d.horizontal, vga_d.vertical, vga_d.hsync_n, vga_d.vsync_n,
                       vga_d.video_on, vga_d.pixel_tick, vga_d.frame_start});
            pop_cmp_s({vga_s.horizontal, vga_s.vertical, vga_s.hsync_n, vga_s.vsync_n,
                       vga_s.video_on, vga_s.pixel_tick, vga_s.frame_start});
            if (!rst_n) begin
                last_line  = -1;
                last_frame = -1;
            end else begin
                if (vga_d.horizontal == 10'd0 && vga_d.pixel_tick) begin
                    if (last_line >= 0) cmp_int("line_period", cyc - last_line, 800 * DIV);
                    last_line = cyc;
                end
                if (vga_s.frame_start) begin
                    if (last_frame >= 0) begin
                        cmp_int("frame_period", cyc - last_frame, FRAME_S * DIV);
                        frame_gaps++;
                    end
                    last_frame = cyc;
                end
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;
        repeat (2 * FRAME_S * DIV + $urandom_range(100, 1500)) @(posedge clk);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #($urandom_range(1, 4)) rst_n = 1'b0;
            repeat ($urandom_range(2, 6)) @(posedge clk);
            @(negedge clk);
            #2 rst_n = 1'b1;
            repeat ($urandom_range(50, 3000)) @(posedge clk);
        end
        @(negedge clk);
        #1;
        checks++;
        if (frame_gaps == 0) begin
            errors++;
            $display("FAIL frame_gap_seen: got 0 intervals, want at least 1");
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
